div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the EX stage; the requester side of the stall network.
//  Raises stallreq_o (wired to stall_ctrl stallreq_ex) while a divide is in flight.
//  Consumes the EX-hold bit of the stall vector so a finished result survives later-stage stalls.
//  Radix-2 restoring algorithm: one quotient bit per cycle, with single-cycle special cases.
// PARAMETERS
//  XLEN   32   operand/result width; the iteration count equals XLEN
// PORTS
//  clk         in   1     clock; all state updates on rising edge
//  rst         in   1     reset; synchronous, active-high
//  start_i     in   1     EX holds a divide op; level, held high while instruction sits in EX
//  op_i        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start_i in IDLE)
//  dividend_i  in   XLEN  rs1 value
//  divisor_i   in   XLEN  rs2 value
//  annul_i     in   1     flush of the EX instruction (branch/exception); aborts the divide
//  hold_i      in   1     stall[3] from stall_ctrl: EX stage frozen this cycle
//  result_o    out  XLEN  quotient or remainder per latched op; valid when ready_o=1
//  ready_o     out  1     result valid (DONE state)
//  stallreq_o  out  1     stall request to stall_ctrl (combinational)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, result_o=0, ready_o=0, stallreq_o=0; rst mid-divide aborts with no result.
//  States: IDLE, CALC, DONE (registered, 2-bit).
//  IDLE: start_i&~annul_i at cycle T -> latch op, |dividend|, |divisor| (abs only for signed ops),
//        quotient-sign = sign(a)^sign(b), remainder-sign = sign(a); counter=0.
//        divisor==0 or (signed & a==0x80000000 & b==-1) -> DONE at T+1; else -> CALC.
//  CALC: shift 33-bit partial remainder left, subtract divisor, keep if non-negative; quotient bit = ~borrow;
//        counter++; after XLEN iterations (T+1..T+32) -> DONE at T+33. annul_i in CALC -> IDLE next cycle.
//  DONE: ready_o=1, result_o stable. hold_i=1 -> stay DONE (no restart); hold_i=0 -> IDLE next cycle.
//        annul_i in DONE -> IDLE, ready_o drops next cycle.
//  stallreq_o = (IDLE & start_i & ~annul_i) | (CALC & ~annul_i); always 0 in DONE.
//  Normal divide: stallreq_o high T..T+32 (33 cycles); special case: high at T only.
//  Sign fix-up on DONE entry: quotient negated if q-sign and signed op; remainder negated if r-sign and signed op.
//  Divide by zero: quotient=all ones (0xFFFFFFFF), remainder=dividend (both signed and unsigned).
//  Signed overflow 0x80000000/-1: quotient=0x80000000, remainder=0.
//  start_i high on the cycle after DONE->IDLE is a new instruction and starts a fresh divide.
//  Operand inputs are ignored outside IDLE; changes mid-CALC have no effect.
//  Internal widths: partial remainder XLEN+1 bits; counter $clog2(XLEN)+1 bits; no wrap.
// STRUCTURE
//  defines.v: op encodings (`DivOpDiv/`DivOpDivu/`DivOpRem/`DivOpRemu), state encodings
//    (`DivIdle/`DivCalc/`DivDone), `DivCycles.
//  Single module, no sub-module; the iteration datapath is small enough to stay inline.
// TESTING
//  DIV 100/7 start at T -> stallreq_o high T..T+32, ready_o=1 at T+33, result_o=14; REM -> 2.
//  DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1); DIVU same operands -> 0x7FFFFFFC.
//  DIVU 5/0 -> ready_o at T+1, result 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
//  annul_i at CALC iteration 10 -> state IDLE next cycle, stallreq_o=0 that cycle, ready_o never asserted.
//  DONE with hold_i=1 for 3 cycles -> result_o/ready_o constant, stallreq_o=0, no restart; then hold_i=0 -> IDLE.
//  rst at CALC iteration 20 -> next cycle all outputs 0; back-to-back DIVs: 2nd starts cycle after 1st DONE.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings for the RV32M iterative divider: op codes, FSM states and op decode.
package div_unit_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_CALC = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  localparam int DIV_CYCLES = 32;

  typedef struct packed {
    logic is_signed;
    logic want_rem;
  } div_op_t;

  // Bit 0 clear selects the signed variants (DIV/REM); bit 1 selects the remainder.
  function automatic div_op_t decode_op(input logic [1:0] op);
    div_op_t d;
    d.is_signed = ~op[0];
    d.want_rem  = op[1];
    return d;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls EX while iterating and
// parks the finished result in DONE for as long as EX is held.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  input  logic            hold_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state_q,     state_d;
  logic [CW-1:0]   counter_q,   counter_d;
  logic [XLEN:0]   rem_q,       rem_d;
  logic [XLEN-1:0] quo_q,       quo_d;
  logic [XLEN-1:0] divisor_q,   divisor_d;
  logic [XLEN-1:0] result_q,    result_d;
  logic            want_rem_q,  want_rem_d;
  logic            q_neg_q,     q_neg_d;
  logic            r_neg_q,     r_neg_d;

  div_op_t         op_dec;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN+1:0] diff;
  logic            borrow;

  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    op_dec = decode_op(op_i);
    a_neg  = op_dec.is_signed & dividend_i[XLEN-1];
    b_neg  = op_dec.is_signed & divisor_i[XLEN-1];
    a_abs  = neg_if(a_neg, dividend_i);
    b_abs  = neg_if(b_neg, divisor_i);
  end

  // Trial subtraction is two bits wider than the divisor so the borrow is exact
  // even when the shifted partial remainder has its top bit set.
  always_comb begin
    diff   = {rem_q, quo_q[XLEN-1]} - {2'b00, divisor_q};
    borrow = diff[XLEN+1];
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    want_rem_d = want_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          want_rem_d = op_dec.want_rem;
          q_neg_d    = a_neg ^ b_neg;
          r_neg_d    = a_neg;
          quo_d      = a_abs;
          divisor_d  = b_abs;
          rem_d      = '0;
          counter_d  = '0;
          if (divisor_i == '0) begin
            result_d = op_dec.want_rem ? dividend_i : '1;
            state_d  = DIV_DONE;
          end else if (op_dec.is_signed && dividend_i == MIN_NEG && divisor_i == '1) begin
            result_d = op_dec.want_rem ? '0 : MIN_NEG;
            state_d  = DIV_DONE;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end

      DIV_CALC: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d     = borrow ? {rem_q[XLEN-1:0], quo_q[XLEN-1]} : diff[XLEN:0];
          quo_d     = {quo_q[XLEN-2:0], ~borrow};
          counter_d = counter_q + CW'(1);
          if (counter_q == CW'(XLEN - 1)) begin
            result_d = want_rem_q ? neg_if(r_neg_q, rem_d[XLEN-1:0])
                                  : neg_if(q_neg_q, quo_d);
            state_d  = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        // Annul wins over hold: a flushed instruction must not keep its result parked.
        if (annul_i || !hold_i) begin
          state_d = DIV_IDLE;
        end
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      counter_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      want_rem_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      want_rem_q <= want_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = (state_q == DIV_DONE);
  assign stallreq_o = ((state_q == DIV_IDLE) && start_i && !annul_i) ||
                      ((state_q == DIV_CALC) && !annul_i);

endmodule
